// File: rtl/fft_twiddle_gen_pkg.sv
// Shared constants and state encoding for the 2D FFT twiddle generator.
// Twiddles are signed Q8 words (1.0 = 256) sized for the butterfly multiplier.
package fft_twiddle_gen_pkg;

    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int WW    = 16;
    localparam int FRAC  = 8;
    localparam int IW    = LOG2N - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fft_twiddle_rom.sv
// Combinational N-entry cosine/sine table in Q8, rounded half away from zero.
// Returns cos and +sin; the caller decides the sign of the imaginary part.
module fft_twiddle_rom
    import fft_twiddle_gen_pkg::*;
(
    input  logic [LOG2N-1:0]     k,
    output logic signed [WW-1:0] cos_v,
    output logic signed [WW-1:0] sin_v
);

    always_comb begin
        cos_v = '0;
        sin_v = '0;
        case (k)
            5'd0:  begin cos_v =  16'sd256; sin_v =  16'sd0;   end
            5'd1:  begin cos_v =  16'sd251; sin_v =  16'sd50;  end
            5'd2:  begin cos_v =  16'sd237; sin_v =  16'sd98;  end
            5'd3:  begin cos_v =  16'sd213; sin_v =  16'sd142; end
            5'd4:  begin cos_v =  16'sd181; sin_v =  16'sd181; end
            5'd5:  begin cos_v =  16'sd142; sin_v =  16'sd213; end
            5'd6:  begin cos_v =  16'sd98;  sin_v =  16'sd237; end
            5'd7:  begin cos_v =  16'sd50;  sin_v =  16'sd251; end
            5'd8:  begin cos_v =  16'sd0;   sin_v =  16'sd256; end
            5'd9:  begin cos_v = -16'sd50;  sin_v =  16'sd251; end
            5'd10: begin cos_v = -16'sd98;  sin_v =  16'sd237; end
            5'd11: begin cos_v = -16'sd142; sin_v =  16'sd213; end
            5'd12: begin cos_v = -16'sd181; sin_v =  16'sd181; end
            5'd13: begin cos_v = -16'sd213; sin_v =  16'sd142; end
            5'd14: begin cos_v = -16'sd237; sin_v =  16'sd98;  end
            5'd15: begin cos_v = -16'sd251; sin_v =  16'sd50;  end
            5'd16: begin cos_v = -16'sd256; sin_v =  16'sd0;   end
            5'd17: begin cos_v = -16'sd251; sin_v = -16'sd50;  end
            5'd18: begin cos_v = -16'sd237; sin_v = -16'sd98;  end
            5'd19: begin cos_v = -16'sd213; sin_v = -16'sd142; end
            5'd20: begin cos_v = -16'sd181; sin_v = -16'sd181; end
            5'd21: begin cos_v = -16'sd142; sin_v = -16'sd213; end
            5'd22: begin cos_v = -16'sd98;  sin_v = -16'sd237; end
            5'd23: begin cos_v = -16'sd50;  sin_v = -16'sd251; end
            5'd24: begin cos_v =  16'sd0;   sin_v = -16'sd256; end
            5'd25: begin cos_v =  16'sd50;  sin_v = -16'sd251; end
            5'd26: begin cos_v =  16'sd98;  sin_v = -16'sd237; end
            5'd27: begin cos_v =  16'sd142; sin_v = -16'sd213; end
            5'd28: begin cos_v =  16'sd181; sin_v = -16'sd181; end
            5'd29: begin cos_v =  16'sd213; sin_v = -16'sd142; end
            5'd30: begin cos_v =  16'sd237; sin_v = -16'sd98;  end
            5'd31: begin cos_v =  16'sd251; sin_v = -16'sd50;  end
            default: ;
        endcase
    end

endmodule

// File: rtl/fft_twiddle_gen.sv
// Sweeps (n1,n2) over one FFT stage and streams the W2/W3/W4 twiddle triples
// on a valid/ready interface; inv selects conjugated (IFFT) twiddles.
module fft_twiddle_gen
    import fft_twiddle_gen_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    stage,
    input  logic          inv,
    output logic          busy,
    output logic          done,
    output logic          tw_valid,
    input  logic          tw_ready,
    output logic          tw_last,
    output logic [IW-1:0] n1_o,
    output logic [IW-1:0] n2_o,
    output logic [WW-1:0] W_real_2,
    output logic [WW-1:0] W_imag_2,
    output logic [WW-1:0] W_real_3,
    output logic [WW-1:0] W_imag_3,
    output logic [WW-1:0] W_real_4,
    output logic [WW-1:0] W_imag_4
);

    state_t state, state_nxt;

    logic [2:0]       stage_q;
    logic             inv_q;
    logic [IW-1:0]    n1, n2, hm1;
    logic             loaded_all;
    logic             start_ok, accept, load_en, last_pos;
    logic [LOG2N-1:0] k2, k3, k4;

    logic signed [WW-1:0] c2, s2, c3, s3, c4, s4;

    logic                 vld_p0, last_p0, done_p0;
    logic [IW-1:0]        n1_p0, n2_p0;
    logic signed [WW-1:0] w2r_p0, w2i_p0, w3r_p0, w3i_p0, w4r_p0, w4i_p0;

    // Forward twiddles carry -sin; the inverse transform uses the conjugate.
    function automatic logic signed [WW-1:0] imag_of(input logic signed [WW-1:0] s,
                                                     input logic conj);
        return conj ? s : -s;
    endfunction

    function automatic logic [LOG2N-1:0] expo(input logic [LOG2N-1:0] idx,
                                              input logic [2:0] sh);
        return idx << sh;
    endfunction

    assign start_ok = start && (int'(stage) < LOG2N);
    assign hm1      = IW'((N >> (int'(stage_q) + 1)) - 1);
    assign last_pos = (n1 == hm1) && (n2 == hm1);
    assign accept   = vld_p0 && tw_ready;
    assign load_en  = (state == RUN) && !loaded_all && (!vld_p0 || tw_ready);

    assign k2 = expo({1'b0, n2}, stage_q);
    assign k3 = expo({1'b0, n1}, stage_q);
    assign k4 = expo({1'b0, n1} + {1'b0, n2}, stage_q);

    fft_twiddle_rom u_rom2 (.k(k2), .cos_v(c2), .sin_v(s2));
    fft_twiddle_rom u_rom3 (.k(k3), .cos_v(c3), .sin_v(s3));
    fft_twiddle_rom u_rom4 (.k(k4), .cos_v(c4), .sin_v(s4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = RUN;
            RUN:     if (accept && last_p0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q    <= '0;
            inv_q      <= 1'b0;
            n1         <= '0;
            n2         <= '0;
            loaded_all <= 1'b0;
            vld_p0     <= 1'b0;
            last_p0    <= 1'b0;
            done_p0    <= 1'b0;
        end else begin
            done_p0 <= (state == RUN) && accept && last_p0;
            if ((state == IDLE) && start_ok) begin
                stage_q    <= stage;
                inv_q      <= inv;
                n1         <= '0;
                n2         <= '0;
                loaded_all <= 1'b0;
            end else if (load_en) begin
                if (last_pos) loaded_all <= 1'b1;
                if (n2 == hm1) begin
                    n2 <= '0;
                    n1 <= n1 + 1'b1;
                end else begin
                    n2 <= n2 + 1'b1;
                end
            end
            if (load_en) begin
                vld_p0  <= 1'b1;
                last_p0 <= last_pos;
            end else if (accept) begin
                vld_p0  <= 1'b0;
                last_p0 <= 1'b0;
            end
        end
    end

    // Output stage p0: holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n1_p0  <= '0;
            n2_p0  <= '0;
            w2r_p0 <= '0;
            w2i_p0 <= '0;
            w3r_p0 <= '0;
            w3i_p0 <= '0;
            w4r_p0 <= '0;
            w4i_p0 <= '0;
        end else if (load_en) begin
            n1_p0  <= n1;
            n2_p0  <= n2;
            w2r_p0 <= c2;
            w2i_p0 <= imag_of(s2, inv_q);
            w3r_p0 <= c3;
            w3i_p0 <= imag_of(s3, inv_q);
            w4r_p0 <= c4;
            w4i_p0 <= imag_of(s4, inv_q);
        end
    end

    assign busy     = (state == RUN);
    assign done     = done_p0;
    assign tw_valid = vld_p0;
    assign tw_last  = last_p0;
    assign n1_o     = n1_p0;
    assign n2_o     = n2_p0;
    assign W_real_2 = w2r_p0;
    assign W_imag_2 = w2i_p0;
    assign W_real_3 = w3r_p0;
    assign W_imag_3 = w3i_p0;
    assign W_real_4 = w4r_p0;
    assign W_imag_4 = w4i_p0;

endmodule

// File: doc/fft_twiddle_gen.md
Name: fft_twiddle_gen

Overview:
- Produces the twiddle-factor triples (W_real_2/W_imag_2, W_real_3/W_imag_3, W_real_4/W_imag_4) consumed by the 2x2 vector-radix butterfly multiplier in the 2D 32-point parallel FFT.
- For one stage it sweeps all in-block positions (n1,n2) and emits one triple per accepted transfer on a valid/ready stream, alongside the position indices.
- Forward (e^-j) or inverse (conjugate) twiddles are selected per run, so the same datapath serves FFT and IFFT.

Parameters:
- N, 32, transform length per dimension (power of 2).
- LOG2N, 5, log2(N).
- WW, 16, twiddle word width: signed, Q8 (1.0 = 256), matching the multiplier's [23:8] product slice.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a run; sampled only in IDLE.
- stage  in  3  FFT stage s, 0..LOG2N-1; sampled with start.
- inv  in  1  1 = inverse twiddles (imag sign flipped); sampled with start.
- busy  out  1  high from accepted start until the last triple is accepted.
- done  out  1  one-cycle pulse in the cycle after the last triple is accepted.
- tw_valid  out  1  output triple valid.
- tw_ready  in  1  consumer accepts when tw_valid && tw_ready.
- tw_last  out  1  marks the final triple of the run.
- n1_o, n2_o  out  4 each (LOG2N-1)  position of the current triple.
- W_real_2, W_imag_2, W_real_3, W_imag_3, W_real_4, W_imag_4  out  WW each  twiddle outputs, signed.

Behaviour:
- Reset: state=IDLE. busy, done, tw_valid and tw_last are 0. n1_o, n2_o and all W_* outputs are 0. Reset is asynchronous; asserting it mid-run abandons the run immediately with no done pulse.
- Geometry: H = N >> (s+1), scale = 2^s. The run covers n1 (outer loop) and n2 (inner loop), each 0..H-1, giving H*H triples.
  - Exponents, each taken mod N: k2 = n2*scale, k3 = n1*scale, k4 = (n1+n2)*scale. The maximum is N - 2^(s+1), so no wrap occurs in practice, but the RTL still masks to LOG2N bits.
- Twiddle: W[k] = (round(256*cos(2*pi*k/N)), -round(256*sin(2*pi*k/N))). When inv=1 the imaginary part is negated. Rounding is round-half-away-from-zero. +256 is representable; the value range is -256..256.
- FSM:
  - IDLE: start with stage < LOG2N latches stage and inv, clears n1/n2 and moves to RUN. start with stage >= LOG2N is ignored and the FSM stays in IDLE.
  - RUN: the output register loads when load_en = !tw_valid || tw_ready.
    - Each load writes the triple for the current (n1,n2), sets tw_valid=1, and sets tw_last=1 if n1=n2=H-1. It then advances n2, which wraps to 0 and increments n1.
    - When the last triple has been loaded, no further loads happen. Acceptance of the tw_last triple clears tw_valid, moves the FSM to IDLE and pulses done next cycle.
  - Latency: the first tw_valid appears 1 cycle after the start-accept edge.
  - Throughput: 1 triple per cycle while tw_ready=1.
- Stall: while tw_valid && !tw_ready, all outputs and counters hold stable (AXI-stream rule). tw_valid never drops without acceptance.
- start while busy: ignored, and stage/inv are not re-latched.
- start in the same cycle as done: accepted, because the FSM is already in IDLE.
- Stage LOG2N-1 (H=1): a single triple with tw_last=1, all W = (256,0).

Decomposition:
- Shared package/header holds N, LOG2N, WW, FRAC=8 and the state encoding (IDLE, RUN). Width macros stay consistent with the existing WBus define.
- Sub-module fft_twiddle_rom: combinational N-entry cos/sin case table, indexed by a LOG2N-bit k. It is instantiated three times (k2, k3, k4). Inverse negation is applied in fft_twiddle_gen, not in the ROM.

Test Plan:
- Stage 3, fwd, tw_ready=1 -> 4 triples on consecutive cycles; first valid 1 cycle after start:
  - (0,0): W2=W3=W4=(256,0)
  - (0,1): W2=(0,-256), W3=(256,0), W4=(0,-256)
  - (1,0): W2=(256,0), W3=(0,-256), W4=(0,-256)
  - (1,1): W2=(0,-256), W3=(0,-256), W4=(-256,0), with tw_last=1; done pulses next cycle.
- Stage 0, inv=1 -> 256 triples; the triple at (n1=1,n2=3) is W2=(213,142), W3=(251,50), W4=(181,181); tw_last only at (15,15).
- Stage 2, random tw_ready backpressure -> outputs stable during each stall; exactly 16 acceptances in n1-major order; no duplicates or drops.
- start during RUN with stage=0 -> ignored; the current stage-3 run completes with 4 triples; a start with stage=5 in IDLE -> busy stays 0.
- rst_n asserted after 5 accepted triples of stage 1 -> all outputs 0 asynchronously, no done; a fresh start then produces 64 triples.
- Stage 4 -> single triple (256,0)x3 with tw_last=1; back-to-back start in the done cycle is accepted.
